reg_file_mp: RTL and testbench



---
 rtl/risc16_pkg.sv | 18 +
 rtl/reg_file_rd_port.sv | 96 +++++++++
 rtl/reg_file_mp.sv | 117 +++++++++++
 tb/tb_reg_file_mp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// risc16_pkg -- shared constants and types for the pipelined RiSC-16 core.
//
// Contents:
//   WORD_LEN       data word width
//   REG_ADDR_LEN   register address width
//   REG_FILE_SIZE  number of architectural registers (2**REG_ADDR_LEN)
//   word_t         one data word
//   reg_addr_t     one register address
package risc16_pkg;

  localparam int WORD_LEN      = 16;
  localparam int REG_ADDR_LEN  = 3;
  localparam int REG_FILE_SIZE = 8;

  typedef logic [WORD_LEN-1:0]     word_t;
  typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;

endpackage : risc16_pkg

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port -- one registered read port of the multi-ported register file.
//
// Selects the addressed register from the flattened storage, forces register 0
// to read as zero/not-busy and loads the result into output flops when the
// port is enabled; a disabled port holds its previous outputs.
//
// Optional feature, macro REG_FILE_BYPASS_EN: when defined, an enabled write
// to the addressed register in the same cycle is forwarded to the read
// (highest-indexed matching write port wins).
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_rd_en          read enable for this port
//   i_rd_addr        register address to read
//   i_regs           current storage contents (register 0 slot is zero)
//   i_busy_nxt       scoreboard value that holds after the current edge
//   i_wr_en/addr/data  write ports (bypass build only)
//   o_rd_data        registered read data
//   o_rd_busy        registered busy flag of the register read
module reg_file_rd_port
  import risc16_pkg::*;
#(
`ifdef REG_FILE_BYPASS_EN
  parameter int p_WR_PORTS      = 2,
`endif
  parameter int p_WORD_LEN      = WORD_LEN,
  parameter int p_REG_ADDR_LEN  = REG_ADDR_LEN,
  parameter int p_REG_FILE_SIZE = REG_FILE_SIZE
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_rd_en,
  input  logic [p_REG_ADDR_LEN-1:0]                   i_rd_addr,
  input  logic [p_REG_FILE_SIZE-1:0][p_WORD_LEN-1:0]  i_regs,
  input  logic [p_REG_FILE_SIZE-1:0]                  i_busy_nxt,
`ifdef REG_FILE_BYPASS_EN
  input  logic [p_WR_PORTS-1:0]                       i_wr_en,
  input  logic [p_WR_PORTS*p_REG_ADDR_LEN-1:0]        i_wr_addr,
  input  logic [p_WR_PORTS*p_WORD_LEN-1:0]            i_wr_data,
`endif
  output logic [p_WORD_LEN-1:0]                       o_rd_data,
  output logic                                        o_rd_busy
);

  logic [p_WORD_LEN-1:0] rd_data_q, rd_data_d;
  logic                  rd_busy_q, rd_busy_d;

  // Next-state selection for the read data and busy flag of this port.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    if (i_rd_en) begin
      rd_data_d = i_regs[i_rd_addr];
`ifdef REG_FILE_BYPASS_EN
      // Later ports override earlier ones, matching the write priority.
      for (int w = 0; w < p_WR_PORTS; w++) begin
        if (i_wr_en[w] &&
            (i_wr_addr[w*p_REG_ADDR_LEN +: p_REG_ADDR_LEN] == i_rd_addr)) begin
          rd_data_d = i_wr_data[w*p_WORD_LEN +: p_WORD_LEN];
        end else begin
          // no forwarding from this write port
        end
      end
`endif
      // Busy includes this cycle's reservation/clear so issue sees the
      // state the register will actually be in.
      rd_busy_d = i_busy_nxt[i_rd_addr];
      // Register 0 is constant zero and never busy, even under bypass.
      if (i_rd_addr == {p_REG_ADDR_LEN{1'b0}}) begin
        rd_data_d = {p_WORD_LEN{1'b0}};
        rd_busy_d = 1'b0;
      end else begin
        // non-zero register: keep the selected values
      end
    end else begin
      // port idle: outputs hold
      rd_data_d = rd_data_q;
      rd_busy_d = rd_busy_q;
    end
  end

  // Output flops for this read port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q <= {p_WORD_LEN{1'b0}};
      rd_busy_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign o_rd_data = rd_data_q;
  assign o_rd_busy = rd_busy_q;

endmodule : reg_file_rd_port

// File: rtl/reg_file_mp.sv
// reg_file_mp -- multi-ported register file with busy scoreboard for the
// pipelined RiSC-16 core.
//
// p_RD_PORTS registered read ports, p_WR_PORTS write ports (highest-indexed
// port wins on an address collision), register 0 hard-wired to zero, and a
// per-register busy scoreboard set by reservations and cleared by writes.
// A reservation and a write to the same register in one cycle leave it busy.
//
// Optional feature, macro REG_FILE_BYPASS_EN: same-cycle write-to-read
// forwarding. Undefined (default): a same-cycle read sees the old value.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_rd_en / i_rd_addr     per-port read enable / packed read addresses
//   o_rd_data / o_rd_busy   packed registered read data / busy flags
//   i_wr_en / i_wr_addr / i_wr_data   per-port write enable / address / data
//   i_rsv_en / i_rsv_addr   reserve (mark busy) a destination register
//   o_busy                  live scoreboard vector (bit 0 always 0)
module reg_file_mp
  import risc16_pkg::*;
#(
  parameter int p_WORD_LEN      = WORD_LEN,
  parameter int p_REG_ADDR_LEN  = REG_ADDR_LEN,
  parameter int p_REG_FILE_SIZE = REG_FILE_SIZE,
  parameter int p_RD_PORTS      = 3,
  parameter int p_WR_PORTS      = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [p_RD_PORTS-1:0]                i_rd_en,
  input  logic [p_RD_PORTS*p_REG_ADDR_LEN-1:0] i_rd_addr,
  output logic [p_RD_PORTS*p_WORD_LEN-1:0]     o_rd_data,
  output logic [p_RD_PORTS-1:0]                o_rd_busy,
  input  logic [p_WR_PORTS-1:0]                i_wr_en,
  input  logic [p_WR_PORTS*p_REG_ADDR_LEN-1:0] i_wr_addr,
  input  logic [p_WR_PORTS*p_WORD_LEN-1:0]     i_wr_data,
  input  logic                                 i_rsv_en,
  input  logic [p_REG_ADDR_LEN-1:0]            i_rsv_addr,
  output logic [p_REG_FILE_SIZE-1:0]           o_busy
);

  logic [p_REG_FILE_SIZE-1:0][p_WORD_LEN-1:0] regs_q, regs_d;
  logic [p_REG_FILE_SIZE-1:0]                 busy_q, busy_d;

  // Write decode: later ports are applied last so the highest index wins.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < p_WR_PORTS; w++) begin
      if (i_wr_en[w]) begin
        regs_d[i_wr_addr[w*p_REG_ADDR_LEN +: p_REG_ADDR_LEN]] =
          i_wr_data[w*p_WORD_LEN +: p_WORD_LEN];
      end else begin
        // idle write port leaves storage unchanged
      end
    end
    // Writes to register 0 are discarded; its slot stays constant zero.
    regs_d[0] = {p_WORD_LEN{1'b0}};
  end

  // Scoreboard next state: clears first, then the reservation, so a
  // same-cycle reserve of a written register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < p_WR_PORTS; w++) begin
      if (i_wr_en[w]) begin
        busy_d[i_wr_addr[w*p_REG_ADDR_LEN +: p_REG_ADDR_LEN]] = 1'b0;
      end else begin
        // idle write port clears nothing
      end
    end
    if (i_rsv_en) begin
      busy_d[i_rsv_addr] = 1'b1;
    end else begin
      // no reservation this cycle
    end
    busy_d[0] = 1'b0;
  end

  // Storage and scoreboard flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs_q <= {(p_REG_FILE_SIZE*p_WORD_LEN){1'b0}};
      busy_q <= {p_REG_FILE_SIZE{1'b0}};
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign o_busy = busy_q;

  for (genvar k = 0; k < p_RD_PORTS; k++) begin : g_rd_port
    reg_file_rd_port #(
`ifdef REG_FILE_BYPASS_EN
      .p_WR_PORTS      (p_WR_PORTS),
`endif
      .p_WORD_LEN      (p_WORD_LEN),
      .p_REG_ADDR_LEN  (p_REG_ADDR_LEN),
      .p_REG_FILE_SIZE (p_REG_FILE_SIZE)
    ) u_rd_port (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_rd_en    (i_rd_en[k]),
      .i_rd_addr  (i_rd_addr[k*p_REG_ADDR_LEN +: p_REG_ADDR_LEN]),
      .i_regs     (regs_q),
      .i_busy_nxt (busy_d),
`ifdef REG_FILE_BYPASS_EN
      .i_wr_en    (i_wr_en),
      .i_wr_addr  (i_wr_addr),
      .i_wr_data  (i_wr_data),
`endif
      .o_rd_data  (o_rd_data[k*p_WORD_LEN +: p_WORD_LEN]),
      .o_rd_busy  (o_rd_busy[k])
    );
  end

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp -- directed self-checking bench for reg_file_mp
// (default 3 read ports, 2 write ports, 8 x 16-bit registers).
// Expected values follow REG_FILE_BYPASS_EN when the bench is built with it.
module tb_reg_file_mp;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rd_en;
  logic [8:0]  rd_addr;
  logic [47:0] rd_data;
  logic [2:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic [7:0]  busy;

  int total = 0;
  int bad   = 0;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file_mp dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_rd_busy  (rd_busy),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rd_en = 3'b000; rd_addr = 9'd0;
    wr_en = 2'b00;  wr_addr = 6'd0; wr_data = 32'd0;
    rsv_en = 1'b0;  rsv_addr = 3'd0;
  endtask

  // Advance one clock edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] a;
    rst_n = 1'b0;
    idle();
    #12;
    total++; if (rd_data !== 48'd0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    total++; if (rd_busy !== 3'd0) begin bad++; $display("FAIL reset_rd_busy: got %b want 000", rd_busy); end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL reset_busy: got %h want 00", busy); end
    step();
    rst_n = 1'b1;
    for (int i = 1; i < 8; i++) begin
      a = i[2:0];
      rd_en = 3'b111; rd_addr = {a, a, a};
      step();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (rd_data[k*16 +: 16] !== 16'd0) begin
          bad++; $display("FAIL reset_read r%0d port%0d: got %h want 0000", i, k, rd_data[k*16 +: 16]);
        end
      end
      total++; if (rd_busy !== 3'd0) begin bad++; $display("FAIL reset_read_busy r%0d: got %b want 000", i, rd_busy); end
      total++; if (busy !== 8'h00) begin bad++; $display("FAIL reset_scoreboard r%0d: got %h want 00", i, busy); end
    end
    idle();
  endtask

  task automatic test_write_read();
    wr_en = 2'b01; wr_addr = {3'd0, 3'd3}; wr_data = {16'h0000, 16'hBEEF};
    step();
    idle();
    rd_en = 3'b100; rd_addr = {3'd3, 3'd0, 3'd0};
    step();
    total++; if (rd_data[47:32] !== 16'hBEEF) begin bad++; $display("FAIL write_read_r3: got %h want beef", rd_data[47:32]); end
    total++; if (rd_busy[2] !== 1'b0) begin bad++; $display("FAIL write_read_r3_busy: got %b want 0", rd_busy[2]); end
    // Disabled port holds its last value even with a new address.
    rd_en = 3'b000; rd_addr = {3'd5, 3'd0, 3'd0};
    step();
    total++; if (rd_data[47:32] !== 16'hBEEF) begin bad++; $display("FAIL read_hold: got %h want beef", rd_data[47:32]); end
    idle();
    wr_en = 2'b01; wr_addr = {3'd0, 3'd0}; wr_data = {16'h0000, 16'h1234};
    step();
    idle();
    rd_en = 3'b001; rd_addr = 9'd0;
    step();
    total++; if (rd_data[15:0] !== 16'h0000) begin bad++; $display("FAIL write_r0: got %h want 0000", rd_data[15:0]); end
    idle();
  endtask

  task automatic test_collision();
    wr_en = 2'b11; wr_addr = {3'd5, 3'd5}; wr_data = {16'h2222, 16'h1111};
    step();
    idle();
    rd_en = 3'b010; rd_addr = {3'd0, 3'd5, 3'd0};
    step();
    total++; if (rd_data[31:16] !== 16'h2222) begin bad++; $display("FAIL collision_r5: got %h want 2222", rd_data[31:16]); end
    idle();
  endtask

  task automatic test_same_cycle();
    logic [15:0] exp;
    exp = BYPASS ? 16'hA5A5 : 16'h0000;
    wr_en = 2'b01; wr_addr = {3'd0, 3'd4}; wr_data = {16'h0000, 16'hA5A5};
    rd_en = 3'b001; rd_addr = {3'd0, 3'd0, 3'd4};
    step();
    total++; if (rd_data[15:0] !== exp) begin bad++; $display("FAIL same_cycle_r4: got %h want %h", rd_data[15:0], exp); end
    wr_en = 2'b00;
    step();
    total++; if (rd_data[15:0] !== 16'hA5A5) begin bad++; $display("FAIL next_cycle_r4: got %h want a5a5", rd_data[15:0]); end
    idle();
  endtask

  task automatic test_scoreboard();
    logic [15:0] exp;
    rsv_en = 1'b1; rsv_addr = 3'd6;
    rd_en = 3'b001; rd_addr = {3'd0, 3'd0, 3'd6};
    step();
    total++; if (busy !== 8'h40) begin bad++; $display("FAIL rsv_r6: got %h want 40", busy); end
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL rsv_r6_rd_busy: got %b want 1", rd_busy[0]); end
    idle();
    wr_en = 2'b01; wr_addr = {3'd0, 3'd6}; wr_data = {16'h0000, 16'h6666};
    rsv_en = 1'b1; rsv_addr = 3'd6;
    rd_en = 3'b010; rd_addr = {3'd0, 3'd6, 3'd0};
    step();
    total++; if (busy !== 8'h40) begin bad++; $display("FAIL wr_rsv_r6: got %h want 40", busy); end
    total++; if (rd_busy[1] !== 1'b1) begin bad++; $display("FAIL wr_rsv_r6_rd_busy: got %b want 1", rd_busy[1]); end
    idle();
    exp = BYPASS ? 16'h0606 : 16'h6666;
    wr_en = 2'b10; wr_addr = {3'd6, 3'd0}; wr_data = {16'h0606, 16'h0000};
    rd_en = 3'b100; rd_addr = {3'd6, 3'd0, 3'd0};
    step();
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL wr_clear_r6: got %h want 00", busy); end
    total++; if (rd_busy[2] !== 1'b0) begin bad++; $display("FAIL wr_clear_r6_rd_busy: got %b want 0", rd_busy[2]); end
    total++; if (rd_data[47:32] !== exp) begin bad++; $display("FAIL wr_clear_r6_data: got %h want %h", rd_data[47:32], exp); end
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd0;
    rd_en = 3'b001; rd_addr = 9'd0;
    step();
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL rsv_r0: got %h want 00", busy); end
    total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL rsv_r0_rd_busy: got %b want 0", rd_busy[0]); end
    idle();
  endtask

  task automatic test_async_reset();
    wr_en = 2'b01; wr_addr = {3'd0, 3'd2}; wr_data = {16'h0000, 16'h00FF};
    rsv_en = 1'b1; rsv_addr = 3'd2;
    step();
    idle();
    rd_en = 3'b001; rd_addr = {3'd0, 3'd0, 3'd2};
    step();
    total++; if (rd_data[15:0] !== 16'h00FF) begin bad++; $display("FAIL pre_reset_r2: got %h want 00ff", rd_data[15:0]); end
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL pre_reset_r2_busy: got %b want 1", rd_busy[0]); end
    total++; if (busy !== 8'h04) begin bad++; $display("FAIL pre_reset_scoreboard: got %h want 04", busy); end
    // Assert reset between edges and check without any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (rd_data !== 48'd0) begin bad++; $display("FAIL async_rd_data: got %h want 0", rd_data); end
    total++; if (rd_busy !== 3'd0) begin bad++; $display("FAIL async_rd_busy: got %b want 000", rd_busy); end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL async_busy: got %h want 00", busy); end
    idle();
    step();
    rst_n = 1'b1;
    rd_en = 3'b001; rd_addr = {3'd0, 3'd0, 3'd2};
    step();
    total++; if (rd_data[15:0] !== 16'h0000) begin bad++; $display("FAIL post_reset_r2: got %h want 0000", rd_data[15:0]); end
    total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL post_reset_r2_busy: got %b want 0", rd_busy[0]); end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_same_cycle();
    test_scoreboard();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file_mp
